// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Slot fields are sized by SLOT_AW, which must equal the top-level REG_AW.
package hazard_pkg;

    localparam int SLOT_AW = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic [SLOT_AW-1:0] rd;
        logic               wr;
        logic               ld;
    } slot_t;

    localparam slot_t SLOT_INVALID = '{rd: {SLOT_AW{1'b0}}, wr: 1'b0, ld: 1'b0};

    typedef enum logic [1:0] {
        MODE_NORMAL  = 2'd0,
        MODE_LOADUSE = 2'd1,
        MODE_FLUSH   = 2'd2,
        MODE_FROZEN  = 2'd3
    } mode_e;

    // r0 is hardwired to zero, so it never produces a hazard.
    function automatic logic slot_match(input slot_t s, input logic [SLOT_AW-1:0] src,
                                        input logic use_src);
        return use_src && s.wr && (s.rd == src) && (src != {SLOT_AW{1'b0}});
    endfunction

endpackage

// File: rtl/fwd_sel_logic.sv
// Forward-select decision for one source operand against the ex and mem slots.
// The wb slot is absent on purpose: the register file writes before it is read.
module fwd_sel_logic
    import hazard_pkg::*;
(
    input  logic [SLOT_AW-1:0] src,
    input  logic               use_src,
    input  slot_t              ex_slot,
    input  slot_t              mem_slot,
    output logic [1:0]         sel,
    output logic               ld_hit
);

    logic ex_hit_s;
    logic mem_hit_s;

    // Newest producer wins; a load in ex cannot forward and flags a load-use hit instead.
    always_comb begin
        ex_hit_s  = slot_match(ex_slot, src, use_src);
        mem_hit_s = slot_match(mem_slot, src, use_src);
        ld_hit    = ex_hit_s && ex_slot.ld;
        if (ex_hit_s && !ex_slot.ld) begin
            sel = FWD_EXMEM;
        end else if (mem_hit_s) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Pipeline hazard and forwarding controller: shadow slots for EX/MEM/WB, registered
// operand-mux selects, combinational hold/bubble controls and a load-use stall counter.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              mem_busy,
    input  logic              br_flush,
    output logic              fwd_a_sel1,
    output logic              fwd_a_sel2,
    output logic              fwd_b_sel1,
    output logic              fwd_b_sel2,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              idex_bubble,
    output logic [CNT_W-1:0]  stall_count
);

    slot_t             ex_r;
    slot_t             mem_r;
    slot_t             wb_r;
    logic [1:0]        a_sel_r;
    logic [1:0]        b_sel_r;
    logic [CNT_W-1:0]  cnt_r;

    logic [1:0]        a_sel_s;
    logic [1:0]        b_sel_s;
    logic              a_ld_hit_s;
    logic              b_ld_hit_s;
    mode_e             mode_s;

    fwd_sel_logic u_fwd_a (
        .src      (id_rs),
        .use_src  (id_use_rs),
        .ex_slot  (ex_r),
        .mem_slot (mem_r),
        .sel      (a_sel_s),
        .ld_hit   (a_ld_hit_s)
    );

    fwd_sel_logic u_fwd_b (
        .src      (id_rt),
        .use_src  (id_use_rt),
        .ex_slot  (ex_r),
        .mem_slot (mem_r),
        .sel      (b_sel_s),
        .ld_hit   (b_ld_hit_s)
    );

    // Per-cycle priority decision: freeze, then flush, then load-use, then normal flow.
    always_comb begin
        if (mem_busy) begin
            mode_s = MODE_FROZEN;
        end else if (br_flush) begin
            mode_s = MODE_FLUSH;
        end else if (a_ld_hit_s || b_ld_hit_s) begin
            mode_s = MODE_LOADUSE;
        end else begin
            mode_s = MODE_NORMAL;
        end
    end

    // Hold/bubble controls are same-cycle; forced low while reset is asserted.
    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        idex_bubble = 1'b0;
        if (rst) begin
            pc_hold     = 1'b0;
            ifid_hold   = 1'b0;
            idex_bubble = 1'b0;
        end else begin
            case (mode_s)
                MODE_FROZEN: begin
                    pc_hold   = 1'b1;
                    ifid_hold = 1'b1;
                end
                MODE_FLUSH: begin
                    idex_bubble = 1'b1;
                end
                MODE_LOADUSE: begin
                    pc_hold     = 1'b1;
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                end
                default: begin
                    pc_hold     = 1'b0;
                    ifid_hold   = 1'b0;
                    idex_bubble = 1'b0;
                end
            endcase
        end
    end

    // Slot shift, registered selects and saturating stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_r    <= SLOT_INVALID;
            mem_r   <= SLOT_INVALID;
            wb_r    <= SLOT_INVALID;
            a_sel_r <= FWD_RF;
            b_sel_r <= FWD_RF;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (mode_s)
                MODE_FROZEN: begin
                    ex_r    <= ex_r;
                    mem_r   <= mem_r;
                    wb_r    <= wb_r;
                    a_sel_r <= a_sel_r;
                    b_sel_r <= b_sel_r;
                    cnt_r   <= cnt_r;
                end
                MODE_FLUSH: begin
                    ex_r    <= SLOT_INVALID;
                    mem_r   <= ex_r;
                    wb_r    <= mem_r;
                    a_sel_r <= FWD_RF;
                    b_sel_r <= FWD_RF;
                end
                MODE_LOADUSE: begin
                    ex_r    <= SLOT_INVALID;
                    mem_r   <= ex_r;
                    wb_r    <= mem_r;
                    a_sel_r <= FWD_RF;
                    b_sel_r <= FWD_RF;
                    if (cnt_r != {CNT_W{1'b1}}) begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    ex_r    <= '{rd: id_rd, wr: id_regwrite, ld: id_memread};
                    mem_r   <= ex_r;
                    wb_r    <= mem_r;
                    a_sel_r <= a_sel_s;
                    b_sel_r <= b_sel_s;
                end
            endcase
        end
    end

    assign fwd_a_sel1  = a_sel_r[1];
    assign fwd_a_sel2  = a_sel_r[0];
    assign fwd_b_sel1  = b_sel_r[1];
    assign fwd_b_sel2  = b_sel_r[0];
    assign stall_count = cnt_r;

endmodule
